// File: rtl/fft_post_pkg.sv
// Shared types and width helpers for the FFT spectrum post-processing blocks.
package fft_post_pkg;

  typedef enum logic {IDLE, RUN} frame_st_t;

  function automatic int mag_w(input int dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/cmag_sq.sv
// Three-stage exact |x|^2 pipeline (abs, square, sum) with address/tag riding alongside.
module cmag_sq
  import fft_post_pkg::*;
#(
  parameter  int DW = 16,
  parameter  int AW = 8,
  parameter  int TW = 1,
  localparam int MW = mag_w(DW)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ED,
  input  logic                 in_vld,
  input  logic [AW-1:0]        in_addr,
  input  logic [TW-1:0]        in_tag,
  input  logic signed [DW-1:0] dr,
  input  logic signed [DW-1:0] di,
  output logic [AW-1:0]        rd_addr,
  output logic                 out_vld,
  output logic [AW-1:0]        out_addr,
  output logic [TW-1:0]        out_tag,
  output logic [MW-1:0]        mag
);
  localparam int STAGES = 3;

  logic [STAGES:1] vld_pipe;
  logic [AW-1:0]   addr_pipe [1:STAGES];
  logic [TW-1:0]   tag_pipe  [1:STAGES];
  logic [DW-1:0]   abs_r, abs_i;
  logic [MW-1:0]   sq_r, sq_i;

  // Unsigned DW-bit result, so the most negative input maps to +2^(DW-1).
  function automatic logic [DW-1:0] abs_u(input logic signed [DW-1:0] x);
    logic [DW-1:0] u;
    u = x;
    return u[DW-1] ? (~u) + DW'(1) : u;
  endfunction

  always_ff @(posedge CLK)
    if (RST)     vld_pipe <= '0;
    else if (ED) vld_pipe <= {vld_pipe[STAGES-1:1], in_vld};

  always_ff @(posedge CLK)
    if (ED) begin
      abs_r        <= abs_u(dr);
      abs_i        <= abs_u(di);
      sq_r         <= MW'(abs_r) * MW'(abs_r);
      sq_i         <= MW'(abs_i) * MW'(abs_i);
      mag          <= sq_r + sq_i;
      addr_pipe[1] <= in_addr;
      addr_pipe[2] <= addr_pipe[1];
      addr_pipe[3] <= addr_pipe[2];
      tag_pipe[1]  <= in_tag;
      tag_pipe[2]  <= tag_pipe[1];
      tag_pipe[3]  <= tag_pipe[2];
    end

  // Stage-2 address lets the caller issue a registered RAM read alongside the sum.
  assign rd_addr  = addr_pipe[2];
  assign out_vld  = vld_pipe[STAGES];
  assign out_addr = addr_pipe[STAGES];
  assign out_tag  = tag_pipe[STAGES];

endmodule

// File: rtl/fft_spec_peak.sv
// FFT spectrum post-processor: |X|^2, per-bin exponential averaging and per-frame peak search.
module fft_spec_peak
  import fft_post_pkg::*;
#(
  parameter  int DW    = 16,
  parameter  int LOG2N = 8,
  localparam int MW    = mag_w(DW)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ED,
  input  logic                 RDY_IN,
  input  logic signed [DW-1:0] DR,
  input  logic signed [DW-1:0] DI,
  input  logic [3:0]           ALPHA_SH,
  input  logic                 CLR_AVG,
  input  logic [LOG2N-1:0]     BIN_LO,
  input  logic [LOG2N-1:0]     BIN_HI,
  input  logic [MW-1:0]        THRESH,
  output logic [MW-1:0]        MAG,
  output logic                 MAG_VLD,
  output logic [LOG2N-1:0]     MAG_ADDR,
  output logic [LOG2N-1:0]     PEAK_BIN,
  output logic [MW-1:0]        PEAK_MAG,
  output logic                 PEAK_HIT,
  output logic                 PEAK_VLD
);
  localparam logic [LOG2N-1:0] LAST = '1;

  frame_st_t        st, st_nxt;
  logic [LOG2N-1:0] cnt, cnt_nxt;
  logic             acc, seed_pend, frame_seed, cur_seed;

  always_ff @(posedge CLK)
    if (RST) begin
      st  <= IDLE;
      cnt <= '0;
    end else if (ED) begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
    end

  // An abort cycle accepts no sample; bin 0 of the new frame follows it.
  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    acc     = 1'b0;
    case (st)
      IDLE: if (RDY_IN) begin
        st_nxt  = RUN;
        cnt_nxt = '0;
      end
      RUN: if (cnt == LAST) begin
        acc     = 1'b1;
        cnt_nxt = '0;
        st_nxt  = RDY_IN ? RUN : IDLE;
      end else if (RDY_IN) begin
        cnt_nxt = '0;
      end else begin
        acc     = 1'b1;
        cnt_nxt = cnt + LOG2N'(1);
      end
      default: st_nxt = IDLE;
    endcase
  end

  // Seed mode is latched at bin 0 so a pulse mid-frame only affects the next frame.
  assign cur_seed = (cnt == '0) ? seed_pend : frame_seed;

  always_ff @(posedge CLK)
    if (RST) begin
      seed_pend  <= 1'b1;
      frame_seed <= 1'b0;
    end else if (ED) begin
      if (acc && cnt == '0) frame_seed <= seed_pend;
      if (CLR_AVG)                             seed_pend <= 1'b1;
      else if (acc && cnt == LAST && cur_seed) seed_pend <= 1'b0;
    end

  logic [LOG2N-1:0] rd_addr, s3_addr;
  logic             s3_vld, s3_seed;
  logic [MW-1:0]    s3_mag;

  cmag_sq #(.DW(DW), .AW(LOG2N), .TW(1)) u_cmag (
    .CLK(CLK), .RST(RST), .ED(ED),
    .in_vld(acc), .in_addr(cnt), .in_tag(cur_seed),
    .dr(DR), .di(DI),
    .rd_addr(rd_addr),
    .out_vld(s3_vld), .out_addr(s3_addr), .out_tag(s3_seed), .mag(s3_mag)
  );

  logic [MW-1:0] ram [2**LOG2N];
  logic [MW-1:0] avg_rd, avg_new;
  logic signed [MW:0] diff;

  always_ff @(posedge CLK)
    if (ED) begin
      avg_rd <= ram[rd_addr];
      if (s3_vld) ram[s3_addr] <= avg_new;
    end

  // avg + floor(diff/2^sh) always lies between avg and mag, so MW-bit wrap is exact.
  assign diff    = $signed({1'b0, s3_mag}) - $signed({1'b0, avg_rd});
  assign avg_new = s3_seed ? s3_mag : avg_rd + MW'(diff >>> ALPHA_SH);

  logic             mag_vld_q, pk_vld_q, run_any, in_win, frame_done;
  logic [LOG2N-1:0] run_bin;
  logic [MW-1:0]    run_mag;

  assign in_win     = (s3_addr >= BIN_LO) && (s3_addr <= BIN_HI);
  assign frame_done = mag_vld_q && (MAG_ADDR == LAST);

  always_ff @(posedge CLK)
    if (RST) begin
      MAG       <= '0;
      MAG_ADDR  <= '0;
      mag_vld_q <= 1'b0;
      run_any   <= 1'b0;
      run_bin   <= '0;
      run_mag   <= '0;
      PEAK_BIN  <= '0;
      PEAK_MAG  <= '0;
      PEAK_HIT  <= 1'b0;
      pk_vld_q  <= 1'b0;
    end else if (ED) begin
      mag_vld_q <= s3_vld;
      pk_vld_q  <= frame_done;
      if (frame_done) begin
        PEAK_BIN <= run_bin;
        PEAK_MAG <= run_mag;
        PEAK_HIT <= run_mag > THRESH;
      end
      if (s3_vld) begin
        MAG      <= avg_new;
        MAG_ADDR <= s3_addr;
        // Bin 0 restarts the search; the publish above still sees the previous frame's max.
        if (s3_addr == '0) begin
          run_any <= in_win;
          run_bin <= '0;
          run_mag <= in_win ? avg_new : '0;
        end else if (in_win && (!run_any || avg_new > run_mag)) begin
          run_any <= 1'b1;
          run_bin <= s3_addr;
          run_mag <= avg_new;
        end
      end
    end

  assign MAG_VLD  = mag_vld_q & ED;
  assign PEAK_VLD = pk_vld_q & ED;

endmodule

// File: tb/tb_fft_spec_peak.sv
// Randomised bench for fft_spec_peak against a frame-level array model of magnitude, averaging and peak.
module tb_fft_spec_peak;
  localparam int DW = 16, LOG2N = 8, N = 256, MW = 32;

  logic                 CLK = 1'b0;
  logic                 RST, ED, RDY_IN, CLR_AVG;
  logic signed [DW-1:0] DR, DI;
  logic [3:0]           ALPHA_SH;
  logic [LOG2N-1:0]     BIN_LO, BIN_HI;
  logic [MW-1:0]        THRESH;
  logic [MW-1:0]        MAG, PEAK_MAG;
  logic                 MAG_VLD, PEAK_HIT, PEAK_VLD;
  logic [LOG2N-1:0]     MAG_ADDR, PEAK_BIN;

  fft_spec_peak #(.DW(DW), .LOG2N(LOG2N)) dut (
    .CLK(CLK), .RST(RST), .ED(ED), .RDY_IN(RDY_IN), .DR(DR), .DI(DI),
    .ALPHA_SH(ALPHA_SH), .CLR_AVG(CLR_AVG), .BIN_LO(BIN_LO), .BIN_HI(BIN_HI),
    .THRESH(THRESH), .MAG(MAG), .MAG_VLD(MAG_VLD), .MAG_ADDR(MAG_ADDR),
    .PEAK_BIN(PEAK_BIN), .PEAK_MAG(PEAK_MAG), .PEAK_HIT(PEAK_HIT), .PEAK_VLD(PEAK_VLD)
  );

  always #5 CLK = ~CLK;

  typedef struct {int addr; longint mag;} mexp_t;
  typedef struct {int bin; longint mag; bit hit;} pexp_t;

  mexp_t  exp_q[$];
  pexp_t  pk_q[$];
  int     acc_q[$];
  longint avg_m [N];
  bit     seed_m;
  int     fdr [N], fdi [N];
  int     total = 0, bad = 0;
  int     edcyc = 0, t_last = 0, pk_cnt = 0, ta, pk_before;
  bit     in_rst = 1'b1, mark_acc = 1'b0, mark_last = 1'b0;
  longint mag5 = -1;
  mexp_t  me;
  pexp_t  pe;

  task automatic chk(input string tag, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Whole-frame reference: squares, floor-shift averaging, windowed strict-max search.
  task automatic model_frame(input int nsamp);
    longint m, d;
    pexp_t  p;
    bit     found;
    mexp_t  e;
    for (int k = 0; k < nsamp; k++) begin
      m = longint'(fdr[k]) * fdr[k] + longint'(fdi[k]) * fdi[k];
      if (seed_m) avg_m[k] = m;
      else begin
        d = m - avg_m[k];
        avg_m[k] = avg_m[k] + (d >>> ALPHA_SH);
      end
      e.addr = k;
      e.mag  = avg_m[k];
      exp_q.push_back(e);
    end
    if (nsamp == N) begin
      found = 1'b0; p.bin = 0; p.mag = 0;
      for (int k = int'(BIN_LO); k <= int'(BIN_HI); k++)
        if (!found || avg_m[k] > p.mag) begin
          found = 1'b1; p.bin = k; p.mag = avg_m[k];
        end
      p.hit = p.mag > longint'(THRESH);
      pk_q.push_back(p);
      seed_m = 1'b0;
    end
  endtask

  task automatic cyc(input bit ed, input bit rdy, input int dr, input int di,
                     input bit acc, input bit last);
    @(posedge CLK); #1;
    ED = ed; RDY_IN = rdy; DR = DW'(dr); DI = DW'(di);
    mark_acc = acc; mark_last = last;
  endtask

  task automatic send_frame(input int nsamp, input int ed_pct, input bit drain);
    int n;
    model_frame(nsamp);
    cyc(1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < nsamp; k++) begin
      while ($urandom_range(99) >= ed_pct)
        cyc(1'b0, 1'b0, int'($urandom), int'($urandom), 1'b0, 1'b0);
      cyc(1'b1, 1'b0, fdr[k], fdi[k], 1'b1, k == N - 1);
    end
    if (drain) begin
      n = 0;
      while (n < 12) begin
        bit e = ($urandom_range(99) < ed_pct);
        cyc(e, 1'b0, 0, 0, 1'b0, 1'b0);
        if (e) n++;
      end
    end
  endtask

  task automatic pulse_clr();
    @(posedge CLK); #1;
    ED = 1'b1; RDY_IN = 1'b0; CLR_AVG = 1'b1; mark_acc = 1'b0; mark_last = 1'b0;
    @(posedge CLK); #1;
    CLR_AVG = 1'b0;
    seed_m = 1'b1;
  endtask

  task automatic zero_frame();
    for (int k = 0; k < N; k++) begin fdr[k] = 0; fdi[k] = 0; end
  endtask

  task automatic rnd_frame();
    for (int k = 0; k < N; k++) begin
      fdr[k] = int'($urandom_range(65535)) - 32768;
      fdi[k] = int'($urandom_range(65535)) - 32768;
    end
  endtask

  task automatic chk_outs_zero(input string pfx);
    chk({pfx, "_mag"},    MAG,      0);
    chk({pfx, "_vld"},    MAG_VLD,  0);
    chk({pfx, "_addr"},   MAG_ADDR, 0);
    chk({pfx, "_pkbin"},  PEAK_BIN, 0);
    chk({pfx, "_pkmag"},  PEAK_MAG, 0);
    chk({pfx, "_pkhit"},  PEAK_HIT, 0);
    chk({pfx, "_pkvld"},  PEAK_VLD, 0);
  endtask

  always @(negedge CLK)
    if (!in_rst) begin
      if (!ED) chk("vld_gated", {MAG_VLD, PEAK_VLD}, 0);
      else begin
        if (mark_acc)  acc_q.push_back(edcyc);
        if (mark_last) t_last = edcyc;
        if (MAG_VLD) begin
          if (exp_q.size() == 0 || acc_q.size() == 0) chk("mag_extra", 1, 0);
          else begin
            me = exp_q.pop_front();
            ta = acc_q.pop_front();
            chk("mag_addr", MAG_ADDR, me.addr);
            chk("mag_val",  MAG,      me.mag);
            chk("mag_lat",  edcyc - ta, 4);
          end
          if (MAG_ADDR == 5) mag5 = MAG;
        end
        if (PEAK_VLD) begin
          pk_cnt++;
          if (pk_q.size() == 0) chk("peak_extra", 1, 0);
          else begin
            pe = pk_q.pop_front();
            chk("peak_bin", PEAK_BIN, pe.bin);
            chk("peak_mag", PEAK_MAG, pe.mag);
            chk("peak_hit", PEAK_HIT, pe.hit);
            chk("peak_lat", edcyc - t_last, 5);
          end
        end
        edcyc++;
      end
    end

  initial begin
    RST = 1'b1; ED = 1'b1; RDY_IN = 1'b0; CLR_AVG = 1'b0; DR = '0; DI = '0;
    ALPHA_SH = 4'd0; BIN_LO = 8'd0; BIN_HI = 8'd255; THRESH = '0;
    seed_m = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_outs_zero("rst");
    @(posedge CLK); #1;
    RST = 1'b0; in_rst = 1'b0;

    // most negative components: 2 * 2^30 with no wrap
    for (int k = 0; k < N; k++) begin fdr[k] = -32768; fdi[k] = -32768; end
    send_frame(N, 100, 1'b1);
    chk("neg_pkmag", PEAK_MAG, 64'h8000_0000);
    chk("neg_pkbin", PEAK_BIN, 0);

    // single tone
    zero_frame(); fdr[37] = 1000; BIN_LO = 8'd1;
    send_frame(N, 100, 1'b1);
    chk("tone_bin", PEAK_BIN, 37);
    chk("tone_mag", PEAK_MAG, 1000000);
    chk("tone_hit", PEAK_HIT, 1);

    // averaging with shift 2, then re-seed
    pulse_clr(); ALPHA_SH = 4'd2;
    zero_frame(); fdr[5] = 40;
    send_frame(N, 100, 1'b1); chk("avg_seed", mag5, 1600);
    zero_frame();
    send_frame(N, 100, 1'b1); chk("avg_1", mag5, 1200);
    send_frame(N, 100, 1'b1); chk("avg_2", mag5, 900);
    pulse_clr();
    fdr[5] = 5; fdi[5] = 5;
    send_frame(N, 100, 1'b1); chk("avg_clr", mag5, 50);

    // window excludes bin 0, tie resolves low
    ALPHA_SH = 4'd0; zero_frame();
    fdr[0] = 30000; fdr[10] = 2000; fdr[20] = 2000;
    BIN_LO = 8'd1; BIN_HI = 8'd255; THRESH = '0;
    send_frame(N, 100, 1'b1);
    chk("tie_bin", PEAK_BIN, 10);
    chk("tie_mag", PEAK_MAG, 4000000);
    chk("tie_hit", PEAK_HIT, 1);
    THRESH = 32'd4000000;
    send_frame(N, 100, 1'b1);
    chk("tie_hit_eq", PEAK_HIT, 0);

    // empty window
    BIN_LO = 8'd200; BIN_HI = 8'd100; rnd_frame();
    send_frame(N, 100, 1'b1);
    chk("empty_bin", PEAK_BIN, 0);
    chk("empty_mag", PEAK_MAG, 0);
    chk("empty_hit", PEAK_HIT, 0);

    // abort at cnt=100, then a full frame
    BIN_LO = 8'd0; BIN_HI = 8'd255; THRESH = $urandom;
    pk_before = pk_cnt;
    rnd_frame(); send_frame(100, 100, 1'b0);
    rnd_frame(); send_frame(N, 100, 1'b1);
    chk("abort_pkcnt", pk_cnt - pk_before, 1);

    // random parameters with 50% enable gating
    for (int f = 0; f < 4; f++) begin
      ALPHA_SH = 4'($urandom_range(15));
      BIN_LO = 8'($urandom_range(255)); BIN_HI = 8'($urandom_range(255));
      THRESH = $urandom;
      if ($urandom_range(1) == 1) pulse_clr();
      rnd_frame();
      send_frame(N, 50, 1'b1);
    end

    // reset mid-frame, next frame must seed
    BIN_LO = 8'd0; BIN_HI = 8'd255; ALPHA_SH = 4'd3;
    rnd_frame(); send_frame(60, 100, 1'b0);
    in_rst = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b1; ED = 1'b1; RDY_IN = 1'b0; mark_acc = 1'b0; mark_last = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk_outs_zero("midrst");
    exp_q.delete(); pk_q.delete(); acc_q.delete();
    seed_m = 1'b1; in_rst = 1'b0;
    rnd_frame(); send_frame(N, 100, 1'b1);

    chk("mag_left",  exp_q.size(), 0);
    chk("peak_left", pk_q.size(),  0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
